// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the 5-stage 16-bit core pipeline control
package core_pkg;

   localparam int REG_ADDR_W = 3;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      ERROR    = 2'b10
   } hz_state_t;

endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the E-stage operand source, M result before W result, never for R0
module forward_unit
   import core_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs_e,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  regwrite_m,
   input  logic                  regwrite_w,
   output logic [1:0]            fwd
);

   // youngest producer wins; R0 is hardwired zero so it never forwards
   always_comb begin
      fwd = (regwrite_m && rd_m != '0 && rd_m == rs_e) ? FWD_M :
            (regwrite_w && rd_w != '0 && rd_w == rs_e) ? FWD_W : FWD_RF;
   end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward sequencer with memory-wait watchdog; HAZ_PERF_CNT_EN adds perf counters
module hazard_controller
   import core_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8,
   parameter int PERF_W      = 16
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rs1_e,
   input  logic [REG_ADDR_W-1:0] rs2_e,
   input  logic [REG_ADDR_W-1:0] rd_e,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  regwrite_m,
   input  logic                  regwrite_w,
   input  logic                  load_e,
   input  logic                  pcsrc_e,
   input  logic                  mem_req_m,
   input  logic                  mem_ack,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  stall_e,
   output logic                  stall_m,
   output logic                  flush_d,
   output logic                  flush_e,
   output logic [1:0]            fwd_a_e,
   output logic [1:0]            fwd_b_e,
   output logic                  mem_timeout
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0]     perf_stall_cyc,
   output logic [PERF_W-1:0]     perf_flush_cnt,
   output logic [PERF_W-1:0]     perf_lu_cnt
`endif
);

   hz_state_t        r_state;
   hz_state_t        w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_lu;
   logic             w_run;
   logic             w_hold;
   logic             w_bubble;

   forward_unit u_fwd_a (
      .rs_e       (rs1_e),
      .rd_m       (rd_m),
      .rd_w       (rd_w),
      .regwrite_m (regwrite_m),
      .regwrite_w (regwrite_w),
      .fwd        (fwd_a_e)
   );

   forward_unit u_fwd_b (
      .rs_e       (rs2_e),
      .rd_m       (rd_m),
      .rd_w       (rd_w),
      .regwrite_m (regwrite_m),
      .regwrite_w (regwrite_w),
      .fwd        (fwd_b_e)
   );

   assign w_lu     = load_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
   assign w_run    = rst && r_state == RUN;
   assign w_hold   = rst && r_state != RUN;
   assign w_bubble = w_run && w_lu && !pcsrc_e;

   // while frozen every stage holds and nothing flushes; in RUN a taken branch beats a load-use bubble
   always_comb begin
      stall_f     = w_hold || w_bubble;
      stall_d     = w_hold || w_bubble;
      stall_e     = w_hold;
      stall_m     = w_hold;
      flush_d     = w_run && pcsrc_e;
      flush_e     = w_run && (pcsrc_e || w_lu);
      mem_timeout = rst && r_state == ERROR;
   end

   // ack ends the wait; the watchdog fires once the wait counter would reach MEM_TIMEOUT
   always_comb begin
      w_next = (r_state == RUN)      ? ((mem_req_m && !mem_ack) ? MEM_WAIT : RUN) :
               (r_state == MEM_WAIT) ? (mem_ack ? RUN :
                                        (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT) :
               ERROR;
   end

   // state and wait counter; the counter only runs while waiting so it is zero on entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == MEM_WAIT) ? r_cnt + CNT_W'(1) : '0;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [PERF_W-1:0] r_perf_stall;
   logic [PERF_W-1:0] r_perf_flush;
   logic [PERF_W-1:0] r_perf_lu;

   // saturating event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
         r_perf_lu    <= '0;
      end else begin
         r_perf_stall <= (stall_d && !(&r_perf_stall)) ? r_perf_stall + PERF_W'(1) : r_perf_stall;
         r_perf_flush <= (flush_d && !(&r_perf_flush)) ? r_perf_flush + PERF_W'(1) : r_perf_flush;
         r_perf_lu    <= (w_bubble && !(&r_perf_lu)) ? r_perf_lu + PERF_W'(1) : r_perf_lu;
      end
   end

   assign perf_stall_cyc = r_perf_stall;
   assign perf_flush_cnt = r_perf_flush;
   assign perf_lu_cnt    = r_perf_lu;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed self-checking bench for hazard_controller (HAZ_PERF_CNT_EN adds a perf test)
module tb_hazard_controller;

   logic       clk;
   logic       rst;
   logic [2:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       regwrite_m, regwrite_w, load_e, pcsrc_e, mem_req_m, mem_ack;
   logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout;
   logic [1:0] fwd_a_e, fwd_b_e;
   logic [6:0] ctl;
   int         checks;
   int         errors;
`ifdef HAZ_PERF_CNT_EN
   logic [3:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

   hazard_controller #(.MEM_TIMEOUT(8), .CNT_W(4), .PERF_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .rs1_d          (rs1_d),
      .rs2_d          (rs2_d),
      .rs1_e          (rs1_e),
      .rs2_e          (rs2_e),
      .rd_e           (rd_e),
      .rd_m           (rd_m),
      .rd_w           (rd_w),
      .regwrite_m     (regwrite_m),
      .regwrite_w     (regwrite_w),
      .load_e         (load_e),
      .pcsrc_e        (pcsrc_e),
      .mem_req_m      (mem_req_m),
      .mem_ack        (mem_ack),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .stall_e        (stall_e),
      .stall_m        (stall_m),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .fwd_a_e        (fwd_a_e),
      .fwd_b_e        (fwd_b_e),
      .mem_timeout    (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt),
      .perf_lu_cnt    (perf_lu_cnt)
`endif
   );

   assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {regwrite_m, regwrite_w, load_e, pcsrc_e, mem_req_m, mem_ack} = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #1;
      if (ctl !== 7'b0) begin
         $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      regwrite_m = 1'b1; rd_m = 3'd2; rs1_e = 3'd2;
      #1;
      if (fwd_a_e !== 2'b10) begin
         $display("FAIL reset_fwd: got %b want %b", fwd_a_e, 2'b10);
         errors++;
      end
      checks++;
      idle();
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_forward();
      regwrite_m = 1'b1; regwrite_w = 1'b1; rd_m = 3'd3; rd_w = 3'd3; rs1_e = 3'd3;
      #1;
      if (fwd_a_e !== 2'b10) begin
         $display("FAIL fwd_m_prio: got %b want %b", fwd_a_e, 2'b10);
         errors++;
      end
      checks++;
      regwrite_m = 1'b0;
      #1;
      if (fwd_a_e !== 2'b01) begin
         $display("FAIL fwd_w: got %b want %b", fwd_a_e, 2'b01);
         errors++;
      end
      checks++;
      regwrite_m = 1'b1; rd_m = 3'd0; rd_w = 3'd0; rs1_e = 3'd0;
      #1;
      if (fwd_a_e !== 2'b00) begin
         $display("FAIL fwd_r0: got %b want %b", fwd_a_e, 2'b00);
         errors++;
      end
      checks++;
      rd_m = 3'd4; rd_w = 3'd6; rs1_e = 3'd6; rs2_e = 3'd4;
      #1;
      if ({fwd_a_e, fwd_b_e} !== 4'b0110) begin
         $display("FAIL fwd_ab: got %b want %b", {fwd_a_e, fwd_b_e}, 4'b0110);
         errors++;
      end
      checks++;
      idle();
      tick();
   endtask

   task automatic test_load_use();
      load_e = 1'b1; rd_e = 3'd5; rs2_d = 3'd5;
      @(negedge clk);
      if (ctl !== 7'b1100010) begin
         $display("FAIL lu_bubble: got %b want %b", ctl, 7'b1100010);
         errors++;
      end
      checks++;
      tick();
      idle();
      @(negedge clk);
      if (ctl !== 7'b0) begin
         $display("FAIL lu_one_cycle: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      tick();
      load_e = 1'b1; rd_e = 3'd0; rs1_d = 3'd0; rs2_d = 3'd0;
      @(negedge clk);
      if (ctl !== 7'b0) begin
         $display("FAIL lu_r0: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      tick();
      load_e = 1'b1; rd_e = 3'd2; rs1_d = 3'd2;
      @(negedge clk);
      if (ctl !== 7'b1100010) begin
         $display("FAIL lu_rs1: got %b want %b", ctl, 7'b1100010);
         errors++;
      end
      checks++;
      tick();
      idle();
   endtask

   task automatic test_branch();
      load_e = 1'b1; rd_e = 3'd5; rs1_d = 3'd5; pcsrc_e = 1'b1;
      @(negedge clk);
      if (ctl !== 7'b0000110) begin
         $display("FAIL branch_over_lu: got %b want %b", ctl, 7'b0000110);
         errors++;
      end
      checks++;
      tick();
      idle();
      pcsrc_e = 1'b1;
      @(negedge clk);
      if (ctl !== 7'b0000110) begin
         $display("FAIL branch_only: got %b want %b", ctl, 7'b0000110);
         errors++;
      end
      checks++;
      tick();
      idle();
   endtask

   task automatic test_mem_wait();
      mem_req_m = 1'b1;
      @(negedge clk);
      if (ctl !== 7'b0) begin
         $display("FAIL mem_req_cycle: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      tick();
      idle();
      for (int i = 1; i <= 4; i++) begin
         if (i == 2) begin
            pcsrc_e = 1'b1; load_e = 1'b1; rd_e = 3'd5; rs1_d = 3'd5;
         end else begin
            idle();
         end
         mem_ack = (i == 4);
         @(negedge clk);
         if (ctl !== 7'b1111000) begin
            $display("FAIL mem_wait_c%0d: got %b want %b", i, ctl, 7'b1111000);
            errors++;
         end
         checks++;
         tick();
      end
      idle();
      @(negedge clk);
      if (ctl !== 7'b0) begin
         $display("FAIL mem_release: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      tick();
      mem_req_m = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
      if (ctl !== 7'b0) begin
         $display("FAIL mem_single_cycle: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      tick();
      idle();
      @(negedge clk);
      if (ctl !== 7'b0) begin
         $display("FAIL mem_single_next: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      tick();
   endtask

   task automatic test_timeout();
      mem_req_m = 1'b1;
      tick();
      idle();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (ctl !== 7'b1111000) begin
            $display("FAIL to_wait_c%0d: got %b want %b", i, ctl, 7'b1111000);
            errors++;
         end
         checks++;
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         mem_ack = (i == 1);
         @(negedge clk);
         if (ctl !== 7'b1111001) begin
            $display("FAIL to_error_c%0d: got %b want %b", i, ctl, 7'b1111001);
            errors++;
         end
         checks++;
         tick();
      end
      idle();
      rst = 1'b0;
      #1;
      if ({ctl, fwd_a_e, fwd_b_e} !== 11'b0) begin
         $display("FAIL to_async_rst: got %b want %b", {ctl, fwd_a_e, fwd_b_e}, 11'b0);
         errors++;
      end
      checks++;
      @(negedge clk);
      rst = 1'b1;
      tick();
      load_e = 1'b1; rd_e = 3'd1; rs2_d = 3'd1;
      @(negedge clk);
      if (ctl !== 7'b1100010) begin
         $display("FAIL to_back_in_run: got %b want %b", ctl, 7'b1100010);
         errors++;
      end
      checks++;
      tick();
      idle();
   endtask

   task automatic test_reset_mid_wait();
      mem_req_m = 1'b1;
      tick();
      idle();
      tick();
      rst = 1'b0;
      #1;
      if (ctl !== 7'b0) begin
         $display("FAIL midwait_rst: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      @(negedge clk);
      rst = 1'b1;
      tick();
      @(negedge clk);
      if (ctl !== 7'b0) begin
         $display("FAIL midwait_run: got %b want %b", ctl, 7'b0);
         errors++;
      end
      checks++;
      tick();
      mem_req_m = 1'b1;
      tick();
      idle();
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (ctl !== ((i == 9) ? 7'b1111001 : 7'b1111000)) begin
            $display("FAIL midwait_rewait_c%0d: got %b want %b", i, ctl,
                     (i == 9) ? 7'b1111001 : 7'b1111000);
            errors++;
         end
         checks++;
         tick();
      end
      do_reset();
   endtask

`ifdef HAZ_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         load_e = 1'b1; rd_e = 3'd5; rs2_d = 3'd5;
         tick();
         idle();
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         pcsrc_e = 1'b1;
         tick();
         idle();
         tick();
      end
      @(negedge clk);
      if ({perf_lu_cnt, perf_flush_cnt, perf_stall_cyc} !== {4'd3, 4'd2, 4'd3}) begin
         $display("FAIL perf_counts: got %h want %h",
                  {perf_lu_cnt, perf_flush_cnt, perf_stall_cyc}, {4'd3, 4'd2, 4'd3});
         errors++;
      end
      checks++;
      mem_req_m = 1'b1;
      tick();
      idle();
      for (int i = 0; i < 20; i++) tick();
      @(negedge clk);
      if ({perf_lu_cnt, perf_stall_cyc} !== {4'd3, 4'hF}) begin
         $display("FAIL perf_saturate: got %h want %h", {perf_lu_cnt, perf_stall_cyc}, {4'd3, 4'hF});
         errors++;
      end
      checks++;
      do_reset();
      if ({perf_lu_cnt, perf_flush_cnt, perf_stall_cyc} !== 12'h0) begin
         $display("FAIL perf_reset: got %h want %h", {perf_lu_cnt, perf_flush_cnt, perf_stall_cyc}, 12'h0);
         errors++;
      end
      checks++;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      idle();
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
`ifdef HAZ_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
